perf_event_monitor: RTL and testbench
=====================================

# perf_event_monitor

Synthesizable, parametrised performance-monitor block for the pipelined processor, replacing the fixed four-event simulation-only counting in the processor test harness. It counts up to NUM_EVENTS per-cycle event strobes plus a free-running cycle counter, freezes on halt, and exposes counts through a snapshot/readout port. It sits beside the processor core; event strobes come from MEM/WB and cache-controller outputs.

## Interface
- NUM_EVENTS, 6: number of event channels, range 1–16.
- CNT_W, 32: width of every counter, including the cycle counter, range 8–64.
- SAT, 1: overflow mode. 1 = saturate at all-ones. 0 = wrap to 0.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of live counters, overflow flags and halt state.
- event_in  in  NUM_EVENTS  per-cycle event strobes; bit i increments channel i.
- halt  in  1  processor halt strobe, taken from MEM/WB.
- snap  in  1  capture all live counters into the shadow registers.
- rd_sel  in  $clog2(NUM_EVENTS+1)  readout select; 0..NUM_EVENTS-1 selects an event channel, NUM_EVENTS selects the cycle counter.
- rd_data  out  CNT_W  registered shadow value for the selected channel.
- cycle_count  out  CNT_W  live cycle counter.
- overflow  out  NUM_EVENTS+1  sticky per-channel overflow; the MSB belongs to the cycle counter.
- halted  out  1  high in the HALTED state.
- done  out  1  one-cycle pulse on entry to HALTED.

## Operation
- The state machine has two states, RUN and HALTED.
  - On rst: go to RUN, and all counters, shadows, overflow, rd_data, halted and done become 0.
  - RUN → HALTED: on a cycle with halt=1. Events and the cycle tick of that same cycle are still counted, so the halt instruction counts as retired.
  - HALTED → RUN: only on clr.
  - While HALTED: no counter changes; further halt strobes are ignored.
- Counting in RUN:
  - Each cycle, cycle_count += 1.
  - Channel i += 1 when event_in[i]=1.
  - At most +1 per channel per cycle.
- Overflow handling:
  - An increment from all-ones sets overflow[i]. The flag is sticky until rst or clr.
  - SAT=1: the counter holds at all-ones.
  - SAT=0: the counter wraps to 0.
- clr:
  - Zeroes the live counters and overflow, and returns the block to RUN.
  - Shadows are not affected.
  - Events in the clr cycle are discarded.
- snap:
  - The shadow takes the counter's next value, including events of the snap cycle.
  - snap and clr in the same cycle: the shadow gets the pre-clear next value, then the live counters zero.
  - snap in HALTED captures the frozen values.
- Readout:
  - rd_data <= shadow[rd_sel] every cycle.
  - An rd_sel value above NUM_EVENTS returns 0.
- Precedence: rst > clr > halt > count.

## Timing
- Event sampled at edge N becomes visible in the live counter after edge N.
- done goes high in the cycle after the halt cycle, for exactly one cycle.
- The snap edge is visible at rd_data two edges later: one edge for the snap, one for the readout register.
- An rd_sel change reaches rd_data with 1-cycle latency.
- No combinational path from inputs to outputs.

## Structure
- Package perf_pkg holds:
  - event index constants: EV_RETIRE=0, EV_ICREQ=1, EV_ICHIT=2, EV_DCREQ=3, EV_DCHIT=4, EV_MEMRD=5.
  - the state encoding: RUN=1'b0, HALTED=1'b1.
- Sub-module perf_ctr: one counter slice with live register, shadow register, sticky overflow and the SAT behaviour.
  - It is instantiated NUM_EVENTS+1 times; the top level holds the FSM and the readout mux.

## Test plan
- Reset, then 10 cycles with event_in=6'b000001, then snap; read rd_sel=0 and rd_sel=6 -> 10 and 10. overflow=0.
- CNT_W=8, SAT=1, event 3 held high for 300 cycles -> channel 3 reads 255 and overflow[3]=1. With SAT=0 -> channel 3 reads 44 (300 mod 256) and overflow[3]=1.
- halt together with event_in[0] in cycle 5 -> channel 0 counts that cycle; halted=1 and done pulses once; counts stay frozen for 20 further cycles with events active; a second halt gives no done pulse.
- snap and clr in the same cycle after 7 events on channel 1 -> shadow reads 8 (event in that cycle included); live counter is 0 next cycle; overflow cleared.
- From HALTED, apply clr -> RUN, cycle_count restarts from 0; 3 events on channel 2 then snap -> reads 3.
- rst mid-count with snap in the same cycle -> every output is 0 next cycle and the shadow is 0, since rst wins.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared constants for the performance-monitor block: event channel
// assignments and the run/halt state encoding.
package perf_pkg;

  // Event channel indices as wired from MEM/WB and the cache controllers.
  localparam int unsigned EV_RETIRE = 0;
  localparam int unsigned EV_ICREQ  = 1;
  localparam int unsigned EV_ICHIT  = 2;
  localparam int unsigned EV_DCREQ  = 3;
  localparam int unsigned EV_DCHIT  = 4;
  localparam int unsigned EV_MEMRD  = 5;

  // Monitor state: counting, or frozen after the processor halted.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/perf_ctr.sv
// One counter slice: live counter, snapshot shadow and sticky overflow flag.
// SAT selects saturate-at-all-ones (1) or wrap-to-zero (0) on overflow.
module perf_ctr
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter bit          SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  input  logic             snap,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             ovf_q, ovf_d;
  logic             bump;

  // Next count ignoring clr; the shadow captures this value so a snap in
  // the same cycle as clr still sees the events of that cycle.
  always_comb begin
    bump    = en && inc;
    cnt_nxt = cnt_q;
    if (bump) begin
      if (cnt_q == '1) cnt_nxt = SAT ? cnt_q : '0;
      else             cnt_nxt = cnt_q + CNT_W'(1);
    end
    cnt_d    = clr ? '0 : cnt_nxt;
    ovf_d    = clr ? 1'b0 : (ovf_q || (bump && (cnt_q == '1)));
    shadow_d = snap ? cnt_nxt : shadow_q;
  end

  // Slice state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cnt    = cnt_q;
  assign shadow = shadow_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/perf_event_monitor.sv
// Performance monitor: NUM_EVENTS event counters plus a cycle counter that
// freeze on processor halt, with snapshot shadows and a registered readout.
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 6,
  parameter int unsigned CNT_W      = 32,
  parameter bit          SAT        = 1'b1,
  localparam int unsigned SEL_W     = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  halt,
  input  logic                  snap,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_W-1:0]      rd_data,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [NUM_EVENTS:0]   overflow,
  output logic                  halted,
  output logic                  done
);

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             run;
  logic [NUM_EVENTS:0] inc_vec;
  logic [NUM_EVENTS:0] ovf_vec;
  logic [CNT_W-1:0] live   [NUM_EVENTS+1];
  logic [CNT_W-1:0] shadow [NUM_EVENTS+1];

  assign run     = (state_q == RUN);
  // Top slot is the cycle counter, which ticks every running cycle.
  assign inc_vec = {1'b1, event_in};

  for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_ctr
    perf_ctr #(
      .CNT_W (CNT_W),
      .SAT   (SAT)
    ) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .en     (run),
      .inc    (inc_vec[g]),
      .snap   (snap),
      .cnt    (live[g]),
      .shadow (shadow[g]),
      .ovf    (ovf_vec[g])
    );
  end

  // Run/halt control; clr outranks halt, and done marks HALTED entry only.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = RUN;
    end else if (run && halt) begin
      state_d = HALTED;
      done_d  = 1'b1;
    end
  end

  // Readout mux over the shadows; out-of-range selects read as zero.
  always_comb begin
    rd_data_d = '0;
    for (int unsigned i = 0; i <= NUM_EVENTS; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data_d = shadow[i];
    end
  end

  // Control and readout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign cycle_count = live[NUM_EVENTS];
  assign overflow    = ovf_vec;
  assign halted      = (state_q == HALTED);
  assign done        = done_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: a 32-bit saturating instance plus 8-bit
// saturating and wrapping instances share one stimulus stream.
module tb_perf_event_monitor;

  logic       clk = 1'b0;
  logic       rst, clr, halt, snap;
  logic [5:0] ev;
  logic [2:0] rd_sel;

  logic [31:0] rd32, cyc32;
  logic [7:0]  rd8s, cyc8s, rd8w, cyc8w;
  logic [6:0]  ovf32, ovf8s, ovf8w;
  logic        h32, d32, h8s, d8s, h8w, d8w;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: unbounded event totals since the last clear, plus the
  // totals captured at the last snap; counter values derive from these.
  longint unsigned tot [7];
  longint unsigned sh  [7];
  longint unsigned rd_tot;
  bit m_h, m_d;

  always #5 clk = ~clk;

  perf_event_monitor #(.NUM_EVENTS(6), .CNT_W(32), .SAT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .event_in(ev), .halt(halt), .snap(snap),
    .rd_sel(rd_sel), .rd_data(rd32), .cycle_count(cyc32), .overflow(ovf32),
    .halted(h32), .done(d32));

  perf_event_monitor #(.NUM_EVENTS(6), .CNT_W(8), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .event_in(ev), .halt(halt), .snap(snap),
    .rd_sel(rd_sel), .rd_data(rd8s), .cycle_count(cyc8s), .overflow(ovf8s),
    .halted(h8s), .done(d8s));

  perf_event_monitor #(.NUM_EVENTS(6), .CNT_W(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .event_in(ev), .halt(halt), .snap(snap),
    .rd_sel(rd_sel), .rd_data(rd8w), .cycle_count(cyc8w), .overflow(ovf8w),
    .halted(h8w), .done(d8w));

  function automatic longint unsigned fold(longint unsigned t, int w, bit sat);
    longint unsigned mx = (longint'(1) << w) - 1;
    if (t <= mx) return t;
    return sat ? mx : (t % (mx + 1));
  endfunction

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_update();
    longint unsigned nt [7];
    if (rst) begin
      for (int i = 0; i < 7; i++) begin tot[i] = 0; sh[i] = 0; end
      rd_tot = 0; m_h = 0; m_d = 0;
    end else begin
      for (int i = 0; i < 6; i++) nt[i] = tot[i] + ((!m_h && ev[i]) ? 1 : 0);
      nt[6] = tot[6] + (!m_h ? 1 : 0);
      rd_tot = (rd_sel <= 3'd6) ? sh[rd_sel] : 0;
      if (snap) for (int i = 0; i < 7; i++) sh[i] = nt[i];
      if (clr) begin
        for (int i = 0; i < 7; i++) tot[i] = 0;
        m_h = 0; m_d = 0;
      end else begin
        for (int i = 0; i < 7; i++) tot[i] = nt[i];
        m_d = !m_h && halt;
        if (halt) m_h = 1;
      end
    end
  endtask

  task automatic check_inst(string tag, longint unsigned rd, longint unsigned cyc,
                            logic [6:0] ovf, logic h, logic d, int w, bit sat);
    logic [6:0] eo;
    longint unsigned mx = (longint'(1) << w) - 1;
    for (int i = 0; i < 7; i++) eo[i] = (tot[i] > mx);
    chk({tag, ".rd_data"}, rd, fold(rd_tot, w, sat));
    chk({tag, ".cycle_count"}, cyc, fold(tot[6], w, sat));
    chk({tag, ".overflow"}, ovf, eo);
    chk({tag, ".halted"}, h, m_h);
    chk({tag, ".done"}, d, m_d);
  endtask

  // One clock: inputs already driven; update the model on the edge, then
  // compare all three instances 1 ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_inst("w32sat", rd32, cyc32, ovf32, h32, d32, 32, 1'b1);
    check_inst("w8sat",  rd8s, cyc8s, ovf8s, h8s, d8s, 8, 1'b1);
    check_inst("w8wrap", rd8w, cyc8w, ovf8w, h8w, d8w, 8, 1'b0);
  endtask

  task automatic drive(bit r, bit c, bit h, bit s, logic [5:0] e, logic [2:0] sel);
    rst = r; clr = c; halt = h; snap = s; ev = e; rd_sel = sel;
  endtask

  typedef struct {
    bit r, c, h, s;
    logic [5:0] ev;
    logic [2:0] sel;
    int n;
    longint unsigned rd, cyc;
    bit eh, ed;
    logic [6:0] eo;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int dones;
    drive(1, 0, 0, 0, 6'h0, 3'd0);

    // {rst,clr,halt,snap,ev,rd_sel,repeat, expected rd,cycle,halted,done,ovf}
    // on the 32-bit instance after the last repetition.
    tbl.push_back('{1,0,0,0,6'h00,3'd0,1,  0, 0,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h01,3'd0,9,  0, 9,0,0,7'h0});
    tbl.push_back('{0,0,0,1,6'h01,3'd0,1,  0,10,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h00,3'd0,1, 10,11,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h00,3'd6,1, 10,12,0,0,7'h0});
    tbl.push_back('{1,0,0,0,6'h00,3'd1,1,  0, 0,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h02,3'd1,7,  0, 7,0,0,7'h0});
    tbl.push_back('{0,1,0,1,6'h02,3'd1,1,  0, 0,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h00,3'd1,1,  8, 1,0,0,7'h0});
    tbl.push_back('{0,0,1,0,6'h00,3'd1,1,  8, 2,1,1,7'h0});
    tbl.push_back('{0,0,0,0,6'h00,3'd1,3,  8, 2,1,0,7'h0});
    tbl.push_back('{0,1,0,0,6'h00,3'd2,1,  0, 0,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h04,3'd2,3,  0, 3,0,0,7'h0});
    tbl.push_back('{0,0,0,1,6'h00,3'd2,1,  0, 4,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h00,3'd2,1,  3, 5,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h07,3'd6,5,  4,10,0,0,7'h0});
    tbl.push_back('{1,0,0,1,6'h07,3'd6,1,  0, 0,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h00,3'd6,1,  0, 1,0,0,7'h0});
    tbl.push_back('{0,0,0,0,6'h00,3'd7,1,  0, 2,0,0,7'h0});

    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].c, tbl[k].h, tbl[k].s, tbl[k].ev, tbl[k].sel);
      for (int j = 0; j < tbl[k].n; j++) step();
      chk($sformatf("tbl%0d.rd", k), rd32, tbl[k].rd);
      chk($sformatf("tbl%0d.cyc", k), cyc32, tbl[k].cyc);
      chk($sformatf("tbl%0d.halted", k), h32, tbl[k].eh);
      chk($sformatf("tbl%0d.done", k), d32, tbl[k].ed);
      chk($sformatf("tbl%0d.ovf", k), ovf32, tbl[k].eo);
    end

    // Channel 3 held for 300 cycles on 8-bit counters: saturate vs wrap.
    drive(1, 0, 0, 0, 6'h00, 3'd3); step();
    drive(0, 0, 0, 0, 6'h08, 3'd3);
    for (int j = 0; j < 299; j++) step();
    drive(0, 0, 0, 1, 6'h08, 3'd3); step();
    drive(0, 0, 0, 0, 6'h00, 3'd3); step();
    chk("ovfseq.sat_rd", rd8s, 255);
    chk("ovfseq.wrap_rd", rd8w, 44);
    chk("ovfseq.w32_rd", rd32, 300);
    chk("ovfseq.sat_ovf3", ovf8s[3], 1);
    chk("ovfseq.wrap_ovf3", ovf8w[3], 1);
    chk("ovfseq.w32_ovf", ovf32, 0);

    // Halt with a retire event in cycle 5, then freeze and a repeated halt.
    drive(1, 0, 0, 0, 6'h00, 3'd0); step();
    drive(0, 0, 0, 0, 6'h01, 3'd0);
    for (int j = 0; j < 4; j++) step();
    drive(0, 0, 1, 0, 6'h01, 3'd0); step();
    chk("halt.halted", h32, 1);
    chk("halt.done", d32, 1);
    chk("halt.cyc", cyc32, 5);
    dones = 0;
    drive(0, 0, 0, 0, 6'h3f, 3'd0);
    for (int j = 0; j < 20; j++) begin step(); dones += d32; end
    chk("halt.extra_done", dones, 0);
    chk("halt.frozen_cyc", cyc32, 5);
    drive(0, 0, 1, 0, 6'h3f, 3'd0); step();
    chk("halt.second_done", d32, 0);
    drive(0, 0, 0, 1, 6'h3f, 3'd0); step();
    drive(0, 0, 0, 0, 6'h00, 3'd0); step();
    chk("halt.ch0_frozen", rd32, 5);

    // Randomised traffic against the reference model.
    drive(1, 0, 0, 0, 6'h00, 3'd0); step();
    for (int j = 0; j < 3000; j++) begin
      drive($urandom_range(399) == 0, $urandom_range(249) == 0,
            $urandom_range(149) == 0, $urandom_range(7) == 0,
            6'($urandom), 3'($urandom_range(7)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
